// File: rtl/qpel_mc_if.sv
// Bundle of control, reference-row and predicted-row signals for the quarter-pel
// motion compensator; the driver side uses master, the compensator uses slave.
interface qpel_mc_if #(
   parameter int BLK = 4,
   parameter int PW  = 8
);
   logic                    start;
   logic [1:0]              frac_x;
   logic [1:0]              frac_y;
   logic                    ref_valid;
   logic                    ref_ready;
   logic [(BLK+1)*PW-1:0]   ref_row;
   logic                    pred_valid;
   logic                    pred_ready;
   logic [BLK*PW-1:0]       pred_row;
   logic                    busy;
   logic                    done;

   modport master (
      output start, frac_x, frac_y, ref_valid, ref_row, pred_ready,
      input  ref_ready, pred_valid, pred_row, busy, done
   );

   modport slave (
      input  start, frac_x, frac_y, ref_valid, ref_row, pred_ready,
      output ref_ready, pred_valid, pred_row, busy, done
   );
endinterface

// File: rtl/qpel_mc.sv
// Quarter-pel motion compensator: bilinear interpolation of BLK+1 streamed
// reference rows into BLK predicted rows, one row per cycle under valid/ready.
module qpel_mc #(
   parameter int BLK = 4,
   parameter int PW  = 8
) (
   input  logic      clk,
   input  logic      rst,
   qpel_mc_if.slave  mc
);
   localparam int RW = (BLK + 1) * PW;
   localparam int OW = BLK * PW;
   localparam int CW = $clog2(BLK + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD0, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      frac_x_q, frac_x_d, frac_y_q, frac_y_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   prev_q, prev_d;
   logic [OW-1:0]   pred_q, pred_d;
   logic            pred_valid_q, pred_valid_d;
   logic            ref_ready;
   logic            pred_xfer;
   logic [2:0]      inv_x, inv_y;
   logic [4:0]      w_a, w_b, w_c, w_d;
   logic [12:0]     acc;
   logic [OW-1:0]   interp_row;

   assign inv_x = 3'd4 - {1'b0, frac_x_q};
   assign inv_y = 3'd4 - {1'b0, frac_y_q};
   assign w_a   = {2'b0, inv_x}    * {2'b0, inv_y};
   assign w_b   = {3'b0, frac_x_q} * {2'b0, inv_y};
   assign w_c   = {2'b0, inv_x}    * {3'b0, frac_y_q};
   assign w_d   = {3'b0, frac_x_q} * {3'b0, frac_y_q};

   // Row above is prev_q, row below is the incoming ref_row; weights sum to 16.
   always_comb begin
      acc        = '0;
      interp_row = '0;
      for (int c = 0; c < BLK; c++) begin
         acc = 13'(w_a) * 13'(prev_q[c*PW +: PW])
             + 13'(w_b) * 13'(prev_q[(c+1)*PW +: PW])
             + 13'(w_c) * 13'(mc.ref_row[c*PW +: PW])
             + 13'(w_d) * 13'(mc.ref_row[(c+1)*PW +: PW])
             + 13'd8;
         interp_row[c*PW +: PW] = PW'(acc >> 4);
      end
   end

   assign pred_xfer = pred_valid_q & mc.pred_ready;

   // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      frac_x_d     = frac_x_q;
      frac_y_d     = frac_y_q;
      cnt_d        = cnt_q;
      prev_d       = prev_q;
      pred_d       = pred_q;
      pred_valid_d = pred_valid_q;
      ref_ready    = 1'b0;
      if (pred_xfer)
         pred_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mc.start) begin
               frac_x_d = mc.frac_x;
               frac_y_d = mc.frac_y;
               cnt_d    = '0;
               state_d  = S_LOAD0;
            end
         end
         S_LOAD0: begin
            ref_ready = 1'b1;
            if (mc.ref_valid) begin
               prev_d  = mc.ref_row;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            // Only accept a row when the output register is free or draining now.
            ref_ready = !pred_valid_q || mc.pred_ready;
            if (mc.ref_valid && ref_ready) begin
               pred_d       = interp_row;
               pred_valid_d = 1'b1;
               prev_d       = mc.ref_row;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == CW'(BLK - 1))
                  state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pred_xfer)
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the row registers are reset as well, since pred_row must read zero after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         frac_x_q     <= '0;
         frac_y_q     <= '0;
         cnt_q        <= '0;
         prev_q       <= '0;
         pred_q       <= '0;
         pred_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frac_x_q     <= frac_x_d;
         frac_y_q     <= frac_y_d;
         cnt_q        <= cnt_d;
         prev_q       <= prev_d;
         pred_q       <= pred_d;
         pred_valid_q <= pred_valid_d;
      end
   end

   assign mc.ref_ready  = ref_ready;
   assign mc.pred_valid = pred_valid_q;
   assign mc.pred_row   = pred_q;
   assign mc.busy       = (state_q == S_LOAD0) || (state_q == S_STREAM) || (state_q == S_DRAIN);
   assign mc.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_qpel_mc.sv
// Self-checking bench for qpel_mc: directed and randomized blocks compared row by
// row against an arithmetic interpolation model, with handshake and timing checks.
module tb_qpel_mc;
   localparam int BLK = 4;
   localparam int PW  = 8;
   localparam int RW  = (BLK + 1) * PW;
   localparam int OW  = BLK * PW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   qpel_mc_if #(.BLK(BLK), .PW(PW)) mc ();
   qpel_mc #(.BLK(BLK), .PW(PW)) dut (.clk(clk), .rst(rst), .mc(mc));

   int vectors     = 0;
   int miscompares = 0;

   logic [RW-1:0] ref_rows [BLK+1];
   logic [OW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int px(input logic [RW-1:0] row, input int c);
      return int'(row[c*PW +: PW]);
   endfunction

   // Reference: plain bilinear quarter-pel formula over the stored window.
   task automatic build_expected(input int fx, input int fy);
      exp_q.delete();
      for (int r = 0; r < BLK; r++) begin
         logic [OW-1:0] o;
         o = '0;
         for (int c = 0; c < BLK; c++) begin
            int v;
            v = ((4-fx)*(4-fy)*px(ref_rows[r], c) + fx*(4-fy)*px(ref_rows[r], c+1)
               + (4-fx)*fy*px(ref_rows[r+1], c) + fx*fy*px(ref_rows[r+1], c+1) + 8) / 16;
            o[c*PW +: PW] = 8'(v);
         end
         exp_q.push_back(o);
      end
   endtask

   // kind 0: ramp 16c+32r, kind 1: alternating 0/1 columns, otherwise random.
   task automatic fill(input int kind);
      for (int r = 0; r <= BLK; r++)
         for (int c = 0; c <= BLK; c++)
            case (kind)
               0:       ref_rows[r][c*PW +: PW] = 8'(16*c + 32*r);
               1:       ref_rows[r][c*PW +: PW] = 8'(c & 1);
               default: ref_rows[r][c*PW +: PW] = 8'($urandom_range(0, 255));
            endcase
   endtask

   task automatic run_block(input int fx, input int fy, input int vprob, input int rprob,
                            input int stall_at, input bit inject_start);
      int ri, got, cyc, last_hs;
      bit done_seen, prev_pv, prev_hs;
      logic [OW-1:0] prev_row;
      build_expected(fx, fy);
      @(negedge clk);
      mc.start = 1'b1; mc.frac_x = 2'(fx); mc.frac_y = 2'(fy);
      mc.ref_valid = 1'b0; mc.pred_ready = 1'b0;
      @(negedge clk);
      mc.start = 1'b0;
      ri = 0; got = 0; cyc = 0; last_hs = -10;
      done_seen = 1'b0; prev_pv = 1'b0; prev_hs = 1'b0; prev_row = '0;
      while (!done_seen && cyc < 2000) begin
         mc.ref_valid = (ri <= BLK) && ($urandom_range(0, 99) < vprob);
         mc.ref_row   = (ri <= BLK) ? ref_rows[ri] : RW'({$urandom(), $urandom()});
         if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5)
            mc.pred_ready = 1'b0;
         else
            mc.pred_ready = ($urandom_range(0, 99) < rprob);
         mc.start  = inject_start && (cyc == 3);
         mc.frac_x = inject_start ? 2'(3 - fx) : 2'(fx);
         mc.frac_y = inject_start ? 2'(3 - fy) : 2'(fy);
         #1;
         if (cyc == 0) begin
            check("start_busy", 64'(mc.busy), 64'd1);
            check("start_ref_ready", 64'(mc.ref_ready), 64'd1);
         end
         if (mc.done) begin
            done_seen = 1'b1;
            check("done_timing", 64'(cyc), 64'(last_hs + 1));
            check("done_busy", 64'(mc.busy), 64'd0);
            check("rows_out", 64'(got), 64'(BLK));
            check("rows_in", 64'(ri), 64'(BLK + 1));
            if (vprob == 100 && rprob == 100 && stall_at < 0)
               check("block_latency", 64'(cyc), 64'(BLK + 2));
         end else begin
            check("busy_level", 64'(mc.busy), 64'd1);
         end
         if (prev_pv && !prev_hs && mc.pred_valid)
            check("pred_hold", 64'(mc.pred_row), 64'(prev_row));
         if (mc.pred_valid && !mc.pred_ready)
            check("ref_ready_full", 64'(mc.ref_ready), 64'd0);
         prev_hs = mc.pred_valid && mc.pred_ready;
         if (prev_hs) begin
            if (exp_q.size() == 0) begin
               check("extra_row", 64'd1, 64'd0);
            end else begin
               check($sformatf("pred_row%0d", got), 64'(mc.pred_row), 64'(exp_q.pop_front()));
            end
            got++;
            last_hs = cyc;
         end
         if (mc.ref_valid && mc.ref_ready) ri++;
         prev_pv  = mc.pred_valid;
         prev_row = mc.pred_row;
         cyc++;
         @(negedge clk);
      end
      if (!done_seen) check("timeout", 64'd0, 64'd1);
      mc.start = 1'b0; mc.ref_valid = 1'b1; mc.pred_ready = 1'b1;
      #1;
      check("done_pulse", 64'(mc.done), 64'd0);
      check("idle_pred_valid", 64'(mc.pred_valid), 64'd0);
      check("idle_ref_ready", 64'(mc.ref_ready), 64'd0);
      mc.ref_valid = 1'b0;
   endtask

   task automatic reset_mid_block();
      fill(2);
      @(negedge clk);
      mc.start = 1'b1; mc.frac_x = 2'd3; mc.frac_y = 2'd1;
      @(negedge clk);
      mc.start = 1'b0; mc.ref_valid = 1'b1; mc.ref_row = ref_rows[0]; mc.pred_ready = 1'b0;
      @(negedge clk);
      mc.ref_row = ref_rows[1];
      @(negedge clk);
      mc.ref_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("rst_ref_ready", 64'(mc.ref_ready), 64'd0);
      check("rst_pred_valid", 64'(mc.pred_valid), 64'd0);
      check("rst_pred_row", 64'(mc.pred_row), 64'd0);
      check("rst_busy", 64'(mc.busy), 64'd0);
      check("rst_done", 64'(mc.done), 64'd0);
      rst = 1'b1;
   endtask

   initial begin
      mc.start = 1'b0; mc.frac_x = '0; mc.frac_y = '0;
      mc.ref_valid = 1'b1; mc.ref_row = '0; mc.pred_ready = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_ref_ready", 64'(mc.ref_ready), 64'd0);
      check("reset_pred_valid", 64'(mc.pred_valid), 64'd0);
      check("reset_pred_row", 64'(mc.pred_row), 64'd0);
      check("reset_busy", 64'(mc.busy), 64'd0);
      check("reset_done", 64'(mc.done), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("idle_ignores_ref", 64'(mc.ref_ready), 64'd0);
      mc.ref_valid = 1'b0;

      fill(0); run_block(0, 0, 100, 100, -1, 1'b0);
      fill(0); run_block(2, 0, 100, 100, -1, 1'b0);
      fill(0); run_block(1, 3, 100, 100, -1, 1'b0);
      fill(1); run_block(2, 0, 100, 100, -1, 1'b0);
      fill(2); run_block(1, 2, 100, 100, 3, 1'b0);
      fill(2); run_block(3, 1, 80, 80, -1, 1'b1);
      reset_mid_block();
      fill(2); run_block(2, 3, 100, 100, -1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         fill(2);
         run_block($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(30, 100), $urandom_range(30, 100), -1, 1'(i & 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/qpel_mc.md
# qpel_mc

Quarter-pel motion compensator: the decoder-side counterpart of the fractional motion estimation path. The estimator selects a half/quarter-pel candidate; this block takes the chosen fractional offset plus the integer-pel reference window and rebuilds the BLK x BLK predicted block. Reference rows stream in one per cycle, and predicted rows stream out under a valid/ready handshake. It feeds the residual/reconstruction stage.

## Interface
- BLK, 4, block width and height in pixels (2..16)
- PW, 8, pixel width in bits (fixed at 8 for this revision)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a block; sampled only in IDLE
- frac_x  in  2  horizontal quarter-pel fraction 0..3, latched on start
- frac_y  in  2  vertical quarter-pel fraction 0..3, latched on start
- ref_valid  in  1  ref_row valid
- ref_ready  out  1  block accepts ref_row this cycle
- ref_row  in  (BLK+1)*PW  one reference row of BLK+1 integer pixels; pixel c at bits [c*PW +: PW]
- pred_valid  out  1  pred_row valid
- pred_ready  in  1  downstream accepts pred_row
- pred_row  out  BLK*PW  one predicted row; pixel c at bits [c*PW +: PW]
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pred row handshake

## Operation
- Reference transfer: ref_valid & ref_ready. Prediction transfer: pred_valid & pred_ready.
- A block consumes exactly BLK+1 reference rows and emits exactly BLK predicted rows.
- States:
  - IDLE: ref_ready=0. start=1 latches frac_x/frac_y, clears the row counter, asserts busy, and moves to LOAD0.
  - LOAD0: ref_ready=1. A transfer stores the row in prev_row and moves to STREAM.
  - STREAM: accepts ref rows k=1..BLK. Each accepted row computes pred row k-1 from (prev_row, new row) into the output register, then replaces prev_row with the new row. After row BLK is accepted, move to DRAIN.
  - DRAIN: wait for the final pred handshake, then move to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- ref_ready in STREAM = !pred_valid | pred_ready, so the output register is never overwritten while holding undelivered data.
- Interpolation for output pixel c of row r: A=row r[c], B=row r[c+1], C=row r+1[c], D=row r+1[c+1], fx=frac_x, fy=frac_y.
  - pred = ((4-fx)(4-fy)A + fx(4-fy)B + (4-fx)fy*C + fx*fy*D + 8) >> 4
  - Weights sum to 16; use a 13-bit unsigned accumulator. The result is at most 255, so there is no saturation.
  - fx=fy=0 must return A exactly.
- start while busy: ignored.
- ref_valid in IDLE or DONE: ignored (ref_ready=0).
- Reset (rst=0, any state, mid-block included):
  - State goes to IDLE; counter and frac registers clear.
  - Outputs: ref_ready=0, pred_valid=0, pred_row=0, busy=0, done=0.
  - Any partial block is discarded.

## Timing
- start accepted at edge t: busy=1 and ref_ready=1 from t+1.
- pred row k-1 is registered at the same edge that accepts ref row k (k≥1), so pred_valid rises 1 cycle after that ref transfer.
- With ref_valid and pred_ready held high: one ref row and one pred row per cycle.
  - First pred_valid appears 2 cycles after ref row 0 is accepted.
  - Block total: start + BLK+1 ref cycles + 1 drain cycle + done.
- pred_valid stays high and pred_row stays stable until pred_ready.
- pred_valid falls the cycle after the last handshake unless a new row is loaded at the same edge.
- done is asserted the cycle after the BLK-th pred handshake; busy falls in that same cycle.
- A new start can be accepted in the cycle after done.

## Test plan
- Integer MV (BLK=4, frac 0,0), ref row r pixel c = 16c+32r: pred row r pixel c = 16c+32r exactly; done one cycle after the 4th pred handshake.
- Half-pel horizontal (frac 2,0), same ref: pred = 16c+32r+8.
- Quarter-pel (frac 1,3), A=0, B=16, C=32, D=48 at row0/col0: pred[0][0] = (0+16+288+144+8)>>4 = 28. Rounding check with A=0, B=1, C=0, D=1, frac 2,0: pred=1.
- Backpressure: pred_ready low for 5 cycles mid-block. Required: pred_row holds, ref_ready=0 while the output is full, no row lost or duplicated, and all 4 rows arrive in order.
- Reset mid-block after 2 ref rows: all outputs 0 the next cycle, busy=0. A following block with fresh data produces correct rows unaffected by the old prev_row.
- start pulsed while busy with different frac: ignored; the current block completes using the originally latched frac.
